// File: rtl/program_loader_if.sv
// Byte/word bus between the boot loader and its neighbours: UART receive
// stream in, UART transmit request out, instruction memory write port out.
//   rx_data/rx_valid/rx_ferr : received byte, one-cycle strobe, framing error
//   tx_busy                  : UART transmitter busy
//   tx_data/tx_start         : byte to transmit, one-cycle transmit request
//   imem_we/addr/wdata       : instruction memory word write port
// master = the loader, slave = the surrounding UART/memory environment.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 15
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_data, rx_valid, rx_ferr, tx_busy,
        output tx_data, tx_start, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid, rx_ferr, tx_busy,
        input  tx_data, tx_start, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. Waits for the host sync byte, answers with one
// ack byte, receives a big-endian 32-bit word count followed by the
// big-endian program words, and writes them to instruction memory from
// word address 0 upward. done releases the core; error reports an abort.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : program_loader_if.master (UART rx/tx and imem write port)
//   sync_seen  : level, sync byte accepted
//   ack_sent   : level, ack byte fully transmitted
//   done       : level, image fully written
//   error      : level, load aborted (framing error or oversize image)
module program_loader #(
    parameter int unsigned ADDR_W    = 15,
    parameter logic [7:0]  SYNC_BYTE = 8'h99,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    program_loader_if.master  bus,
    output logic              sync_seen,
    output logic              ack_sent,
    output logic              done,
    output logic              error
);

    // Index is one bit wider than the address so a full-memory image fits.
    localparam int unsigned IDX_W    = ADDR_W + 1;
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

    localparam logic [2:0] WAIT_SYNC  = 3'd0;
    localparam logic [2:0] SEND_ACK   = 3'd1;
    localparam logic [2:0] WAIT_TX    = 3'd2;
    localparam logic [2:0] RECV_LEN   = 3'd3;
    localparam logic [2:0] RECV_WORDS = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;
    localparam logic [2:0] ERR        = 3'd6;

    logic [2:0]        state, state_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [31:0]       shreg, shreg_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [IDX_W-1:0]  len, len_nxt;
    logic              busy_seen, busy_seen_nxt;
    logic              tx_start_q, tx_start_nxt;
    logic [7:0]        tx_data_q, tx_data_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic              sync_nxt, ack_nxt, done_nxt, error_nxt;

    logic [31:0]       assembled;
    logic              ferr_in;
    logic              last_byte;

    // Word formed by the bytes so far plus the one on the bus this cycle.
    assign assembled = {shreg[23:0], bus.rx_data};
    assign ferr_in   = bus.rx_valid & bus.rx_ferr;
    assign last_byte = bus.rx_valid & (byte_cnt == 2'd3);

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_SYNC;
            byte_cnt   <= 2'd0;
            shreg      <= 32'd0;
            idx        <= '0;
            len        <= '0;
            busy_seen  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            sync_seen  <= 1'b0;
            ack_sent   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            shreg      <= shreg_nxt;
            idx        <= idx_nxt;
            len        <= len_nxt;
            busy_seen  <= busy_seen_nxt;
            tx_start_q <= tx_start_nxt;
            tx_data_q  <= tx_data_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            sync_seen  <= sync_nxt;
            ack_sent   <= ack_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        byte_cnt_nxt  = byte_cnt;
        shreg_nxt     = shreg;
        idx_nxt       = idx;
        len_nxt       = len;
        busy_seen_nxt = busy_seen;
        tx_start_nxt  = 1'b0;
        tx_data_nxt   = tx_data_q;
        we_nxt        = 1'b0;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        sync_nxt      = sync_seen;
        ack_nxt       = ack_sent;
        done_nxt      = done;
        error_nxt     = error;

        case (state)
            WAIT_SYNC: begin
                if (ferr_in) begin
                    state_nxt = ERR;
                end else if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    sync_nxt  = 1'b1;
                    state_nxt = SEND_ACK;
                end
            end

            // Incoming bytes are dropped here and in WAIT_TX.
            SEND_ACK: begin
                if (!bus.tx_busy) begin
                    tx_start_nxt  = 1'b1;
                    tx_data_nxt   = ACK_BYTE;
                    busy_seen_nxt = 1'b0;
                    state_nxt     = WAIT_TX;
                end
            end

            // Busy may rise a cycle or more after the request; only a fall
            // after a seen rise counts as completion.
            WAIT_TX: begin
                if (bus.tx_busy) begin
                    busy_seen_nxt = 1'b1;
                end else if (busy_seen) begin
                    ack_nxt      = 1'b1;
                    byte_cnt_nxt = 2'd0;
                    state_nxt    = RECV_LEN;
                end
            end

            RECV_LEN: begin
                if (ferr_in) begin
                    state_nxt = ERR;
                end else if (bus.rx_valid) begin
                    shreg_nxt    = assembled;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (last_byte) begin
                        if (assembled == 32'd0) begin
                            state_nxt = DONE;
                        end else if ({1'b0, assembled} > CAPACITY) begin
                            state_nxt = ERR;
                        end else begin
                            len_nxt   = IDX_W'(assembled);
                            idx_nxt   = '0;
                            state_nxt = RECV_WORDS;
                        end
                    end
                end
            end

            RECV_WORDS: begin
                if (ferr_in) begin
                    state_nxt = ERR;
                end else if (bus.rx_valid) begin
                    shreg_nxt    = assembled;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (last_byte) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = idx[ADDR_W-1:0];
                        wdata_nxt = assembled;
                        idx_nxt   = idx + IDX_W'(1);
                        if ((idx + IDX_W'(1)) == len) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end

            DONE: begin
                done_nxt = 1'b1;
            end

            ERR: begin
                done_nxt = 1'b0;
            end

            default: begin
                state_nxt = WAIT_SYNC;
            end
        endcase

        if (state_nxt == ERR) begin
            error_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sync_seen, ack_sent, done, error;
    logic model_busy;
    logic hold_busy;

    int checks;
    int failures;
    int wr_cnt;
    int tx_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W+31:0] exp_q[$];

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.tx_busy = model_busy | hold_busy;

    program_loader #(
        .ADDR_W   (ADDR_W),
        .SYNC_BYTE(8'h99),
        .ACK_BYTE (8'hAA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sync_seen(sync_seen),
        .ack_sent (ack_sent),
        .done     (done),
        .error    (error)
    );

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.rx_ferr  = fe;
    endtask

    task automatic rx_idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n);
        send_byte(n[31:24], 1'b0);
        send_byte(n[23:16], 1'b0);
        send_byte(n[15:8], 1'b0);
        send_byte(n[7:0], 1'b0);
    endtask

    // Expected write is queued as the word's last byte is driven.
    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a,
                             input logic expect_write);
        send_byte(w[31:24], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8], 1'b0);
        if (expect_write) exp_q.push_back({a, w});
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
        hold_busy    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic sync_handshake();
        send_byte(8'h99, 1'b0);
        rx_idle();
        for (int i = 0; i < 400 && ack_sent !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_end();
        for (int i = 0; i < 40 && done !== 1'b1 && error !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sync_seen, ack_sent, done, error} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=0000", {sync_seen, ack_sent, done, error});
        end
        checks++;
        if ({bus.tx_start, bus.imem_we} !== 2'b00) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=00", {bus.tx_start, bus.imem_we});
        end
        checks++;
        if (bus.tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int tx0, wr0;
        apply_reset();
        tx0 = tx_cnt;
        wr0 = wr_cnt;
        sync_handshake();
        checks++;
        if (ack_sent !== 1'b1) begin
            failures++;
            $display("FAIL basic_ack got=%b exp=1", ack_sent);
        end
        checks++;
        if (tx_cnt - tx0 !== 1) begin
            failures++;
            $display("FAIL basic_tx_pulses got=%0d exp=1", tx_cnt - tx0);
        end
        send_len(32'd2);
        send_word(32'h12345678, 4'd0, 1'b1);
        send_word(32'hDEADBEEF, 4'd1, 1'b1);
        rx_idle();
        wait_end();
        checks++;
        if ({done, error} !== 2'b10) begin
            failures++;
            $display("FAIL basic_done got=%b exp=10", {done, error});
        end
        checks++;
        if (wr_cnt - wr0 !== 2) begin
            failures++;
            $display("FAIL basic_writes got=%0d exp=2", wr_cnt - wr0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL basic_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_noise();
        int wr0;
        apply_reset();
        wr0 = wr_cnt;
        send_byte(8'h00, 1'b0);
        rx_idle();
        checks++;
        if (sync_seen !== 1'b0) begin
            failures++;
            $display("FAIL noise_00 sync_seen got=%b exp=0", sync_seen);
        end
        send_byte(8'hFF, 1'b0);
        rx_idle();
        checks++;
        if (sync_seen !== 1'b0) begin
            failures++;
            $display("FAIL noise_ff sync_seen got=%b exp=0", sync_seen);
        end
        send_byte(8'h99, 1'b0);
        // Junk during the ack phase must be dropped.
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD4, 1'b0);
        rx_idle();
        checks++;
        if ({sync_seen, ack_sent} !== 2'b10) begin
            failures++;
            $display("FAIL noise_sync got=%b exp=10", {sync_seen, ack_sent});
        end
        for (int i = 0; i < 400 && ack_sent !== 1'b1; i++) @(negedge clk);
        send_len(32'd1);
        send_word(32'hCAFEF00D, 4'd0, 1'b1);
        rx_idle();
        wait_end();
        checks++;
        if ({done, error} !== 2'b10 || wr_cnt - wr0 !== 1) begin
            failures++;
            $display("FAIL noise_load done/error=%b writes=%0d exp=10/1", {done, error}, wr_cnt - wr0);
        end
    endtask

    task automatic test_zero_len();
        int wr0;
        apply_reset();
        wr0 = wr_cnt;
        sync_handshake();
        send_len(32'd0);
        rx_idle();
        wait_end();
        send_word(32'h01020304, 4'd0, 1'b0);
        rx_idle();
        repeat (3) @(negedge clk);
        checks++;
        if ({done, error} !== 2'b10) begin
            failures++;
            $display("FAIL zero_done got=%b exp=10", {done, error});
        end
        checks++;
        if (wr_cnt - wr0 !== 0) begin
            failures++;
            $display("FAIL zero_writes got=%0d exp=0", wr_cnt - wr0);
        end
    endtask

    task automatic test_overflow();
        int wr0;
        logic [31:0] w;
        apply_reset();
        wr0 = wr_cnt;
        sync_handshake();
        send_len(32'h00000011);
        rx_idle();
        wait_end();
        send_word(32'h55AA55AA, 4'd0, 1'b0);
        rx_idle();
        repeat (3) @(negedge clk);
        checks++;
        if ({done, error, sync_seen, ack_sent} !== 4'b0111) begin
            failures++;
            $display("FAIL ovf_17 got=%b exp=0111", {done, error, sync_seen, ack_sent});
        end
        checks++;
        if (wr_cnt - wr0 !== 0) begin
            failures++;
            $display("FAIL ovf_17_writes got=%0d exp=0", wr_cnt - wr0);
        end
        apply_reset();
        wr0 = wr_cnt;
        sync_handshake();
        send_len(32'h00000010);
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            send_word(w, 4'(i), 1'b1);
        end
        rx_idle();
        wait_end();
        checks++;
        if ({done, error} !== 2'b10) begin
            failures++;
            $display("FAIL ovf_16_done got=%b exp=10", {done, error});
        end
        checks++;
        if (wr_cnt - wr0 !== 16 || last_addr !== 4'hF) begin
            failures++;
            $display("FAIL ovf_16_writes got=%0d last=%h exp=16 last=f", wr_cnt - wr0, last_addr);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL ovf_16_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_ferr();
        int wr0;
        apply_reset();
        wr0 = wr_cnt;
        sync_handshake();
        send_len(32'd2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        send_word(32'h99AABBCC, 4'd0, 1'b0);
        rx_idle();
        wait_end();
        checks++;
        if ({done, error, sync_seen, ack_sent} !== 4'b0111) begin
            failures++;
            $display("FAIL ferr_status got=%b exp=0111", {done, error, sync_seen, ack_sent});
        end
        checks++;
        if (wr_cnt - wr0 !== 0) begin
            failures++;
            $display("FAIL ferr_writes got=%0d exp=0", wr_cnt - wr0);
        end
    endtask

    task automatic test_reset_mid_load();
        int wr0;
        apply_reset();
        sync_handshake();
        send_len(32'd2);
        send_word(32'h0BADF00D, 4'd0, 1'b1);
        send_byte(8'h77, 1'b0);
        rx_idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({sync_seen, ack_sent, done, error, bus.tx_start, bus.imem_we} !== 6'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b exp=000000",
                     {sync_seen, ack_sent, done, error, bus.tx_start, bus.imem_we});
        end
        rst = 1'b0;
        exp_q.delete();
        wr0 = wr_cnt;
        sync_handshake();
        send_len(32'd2);
        send_word(32'hFEEDFACE, 4'd0, 1'b1);
        send_word(32'h00C0FFEE, 4'd1, 1'b1);
        rx_idle();
        wait_end();
        checks++;
        if ({done, error} !== 2'b10 || wr_cnt - wr0 !== 2) begin
            failures++;
            $display("FAIL midrst_reload done/error=%b writes=%0d exp=10/2", {done, error}, wr_cnt - wr0);
        end
    endtask

    task automatic test_busy_hold();
        int tx0;
        apply_reset();
        hold_busy = 1'b1;
        tx0 = tx_cnt;
        send_byte(8'h99, 1'b0);
        rx_idle();
        repeat (20) @(negedge clk);
        checks++;
        if (tx_cnt - tx0 !== 0 || {sync_seen, ack_sent} !== 2'b10) begin
            failures++;
            $display("FAIL busy_hold tx_pulses=%0d sync/ack=%b exp=0/10", tx_cnt - tx0, {sync_seen, ack_sent});
        end
        hold_busy = 1'b0;
        for (int i = 0; i < 400 && ack_sent !== 1'b1; i++) @(negedge clk);
        checks++;
        if (tx_cnt - tx0 !== 1 || ack_sent !== 1'b1) begin
            failures++;
            $display("FAIL busy_release tx_pulses=%0d ack=%b exp=1/1", tx_cnt - tx0, ack_sent);
        end
        send_len(32'd1);
        send_word(32'h13579BDF, 4'd0, 1'b1);
        rx_idle();
        wait_end();
        checks++;
        if ({done, error} !== 2'b10 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL busy_load done/error=%b pending=%0d exp=10/0", {done, error}, exp_q.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        hold_busy    = 1'b0;
        model_busy   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
        checks       = 0;
        failures     = 0;
        wr_cnt       = 0;
        tx_cnt       = 0;
        last_addr    = '0;

        fork
            // Write monitor: every imem_we cycle must match the scoreboard head.
            forever begin
                logic [ADDR_W+31:0] e;
                @(negedge clk);
                if (bus.imem_we === 1'b1) begin
                    wr_cnt++;
                    last_addr = bus.imem_addr;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.imem_addr, bus.imem_wdata} !== e) begin
                            failures++;
                            $display("FAIL write got=%h/%h exp=%h/%h",
                                     bus.imem_addr, bus.imem_wdata, e[ADDR_W+31:32], e[31:0]);
                        end
                    end
                end
                if (bus.tx_start === 1'b1) begin
                    tx_cnt++;
                    checks++;
                    if (bus.tx_data !== 8'hAA) begin
                        failures++;
                        $display("FAIL tx_data got=%h exp=aa", bus.tx_data);
                    end
                end
            end
            // UART transmitter model: busy goes high a cycle after the request.
            forever begin
                @(posedge clk);
                #1;
                if (bus.tx_start === 1'b1) begin
                    @(posedge clk);
                    #1 model_busy = 1'b1;
                    repeat (8) @(posedge clk);
                    #1 model_busy = 1'b0;
                end
            end
        join_none

        test_reset();
        test_basic();
        test_noise();
        test_zero_len();
        test_overflow();
        test_ferr();
        test_reset_mid_load();
        test_busy_hold();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
